// File: rtl/fb_capture_packer_pkg.sv
// Shared definitions for the framebuffer capture packer.
//
// Contents:
//   phase_t / PHASE0..PHASE5 : framebuffer slot phase encoding (0..5)
//   POP_PHASE                : phase whose closing edge pops one word
//   ENTRY_W                  : width of one FIFO entry (16-bit word + tag)
//   fb_entry_t               : packed view of a FIFO entry
//   make_entry()             : builds an entry from two bytes and a tag
package fb_capture_packer_pkg;

    localparam int PHASE_W = 3;
    typedef logic [PHASE_W-1:0] phase_t;

    localparam phase_t PHASE0 = 3'd0;
    localparam phase_t PHASE1 = 3'd1;
    localparam phase_t PHASE2 = 3'd2;
    localparam phase_t PHASE3 = 3'd3;
    localparam phase_t PHASE4 = 3'd4;
    localparam phase_t PHASE5 = 3'd5;

    localparam phase_t POP_PHASE = PHASE5;

    localparam int ENTRY_W = 17;

    typedef logic [15:0] word_t;

    typedef struct packed {
        logic  frame_start;
        word_t word;
    } fb_entry_t;

    // The first sample of a pair is the low byte; the tag follows the low byte.
    function automatic fb_entry_t make_entry(input logic tag,
                                             input logic [7:0] hi,
                                             input logic [7:0] lo);
        fb_entry_t e;
        e.frame_start = tag;
        e.word        = {hi, lo};
        return e;
    endfunction

endpackage

// File: rtl/fb_capture_packer_if.sv
// Pixel-in / framebuffer-out bus of the capture packer.
//
// Signals:
//   clk_phase   : framebuffer slot phase, 0..5
//   pix_valid   : pix_data carries a valid sample
//   pix_data    : 8-bit video sample
//   pix_vsync   : first sample of a frame (qualified by pix_valid)
//   fb_data     : 16-bit word presented to the framebuffer
//   fb_reset_in : framebuffer write-address reset, aligned with fb_data
//
// Modports:
//   master : video source side (drives pixels and phase, observes fb outputs)
//   slave  : the packer
interface fb_capture_packer_if;
    import fb_capture_packer_pkg::*;

    phase_t     clk_phase;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_vsync;
    word_t      fb_data;
    logic       fb_reset_in;

    modport master (
        output clk_phase, pix_valid, pix_data, pix_vsync,
        input  fb_data, fb_reset_in
    );

    modport slave (
        input  clk_phase, pix_valid, pix_data, pix_vsync,
        output fb_data, fb_reset_in
    );

endinterface

// File: rtl/fb_word_fifo.sv
// Small circular FIFO of packed framebuffer entries.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : synchronous clear of pointers and level
//   push, push_data : write request and entry
//   pop, pop_data   : read request; pop_data shows the current head
//   level        : number of queued entries, 0..DEPTH
//   full, empty  : status flags derived from level
//
// A push while full succeeds only when a pop happens on the same edge.
module fb_word_fifo
    import fb_capture_packer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;
    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_wr;
    logic               do_rd;

    assign full     = (level == FULL_LEVEL);
    assign empty    = (level == '0);
    assign pop_data = mem[rd_ptr];

    // When full, the simultaneous pop frees the slot the write lands in.
    assign do_wr = push & ~flush & (~full | pop);
    assign do_rd = pop & ~flush & ~empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fb_capture_packer.sv
// Packs 8-bit video samples into 16-bit framebuffer words and hands them to
// the framebuffer once per six-phase slot.
//
// Ports:
//   clk, reset_n : system clock (shared with framebuffer), async active-low reset
//   bus          : slave side of fb_capture_packer_if (pixels in, fb word out)
//   fifo_level   : words currently queued
//   overflow     : sticky, a packed word was dropped on a full FIFO
//   underrun     : sticky, a pop slot found the FIFO empty
module fb_capture_packer
    import fb_capture_packer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    fb_capture_packer_if.slave     bus,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic                   underrun
);

    logic       pending;
    logic [7:0] low_byte;
    logic       low_tag;

    logic       flush;
    logic       push;
    logic       pop_edge;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    fb_entry_t  push_entry;
    logic [ENTRY_W-1:0] head_bits;
    fb_entry_t  head;

    // A vsync sample always starts a new word, so it can never complete one.
    assign flush      = bus.pix_valid & bus.pix_vsync;
    assign push       = bus.pix_valid & ~bus.pix_vsync & pending;
    assign pop_edge   = (bus.clk_phase == POP_PHASE);
    assign pop        = pop_edge & ~flush;
    assign push_entry = make_entry(low_tag, bus.pix_data, low_byte);
    assign head       = fb_entry_t'(head_bits);

    fb_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_bits),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Byte pairing: a vsync sample restarts pairing as a tagged low byte,
    // discarding any half-built word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= 1'b0;
            low_byte <= '0;
            low_tag  <= 1'b0;
        end else if (bus.pix_valid) begin
            if (bus.pix_vsync) begin
                pending  <= 1'b1;
                low_byte <= bus.pix_data;
                low_tag  <= 1'b1;
            end else if (!pending) begin
                pending  <= 1'b1;
                low_byte <= bus.pix_data;
                low_tag  <= 1'b0;
            end else begin
                pending  <= 1'b0;
            end
        end
    end

    // Output register only changes on the pop edge, so it stays stable across
    // the framebuffer's phase-0 sample. A flush on that edge forces an idle word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.fb_data     <= '0;
            bus.fb_reset_in <= 1'b0;
            underrun        <= 1'b0;
        end else if (pop_edge) begin
            if (flush) begin
                bus.fb_data     <= '0;
                bus.fb_reset_in <= 1'b0;
            end else if (fifo_empty) begin
                bus.fb_data     <= '0;
                bus.fb_reset_in <= 1'b0;
                underrun        <= 1'b1;
            end else begin
                bus.fb_data     <= head.word;
                bus.fb_reset_in <= head.frame_start;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_capture_packer.sv
// Self-checking bench for fb_capture_packer: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_fb_capture_packer;
    import fb_capture_packer_pkg::*;

    localparam int DEPTH   = 4;
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic [LEVEL_W-1:0] fifo_level;
    logic overflow;
    logic underrun;

    fb_capture_packer_if bus();

    fb_capture_packer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: queue of {tag, word} entries plus pairing state.
    logic [16:0] m_q[$];
    bit          m_pending;
    logic [7:0]  m_low;
    bit          m_tag;
    logic [15:0] m_data;
    bit          m_rst;
    bit          m_ovf;
    bit          m_und;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_q.delete();
        m_pending = 0;
        m_low     = '0;
        m_tag     = 0;
        m_data    = '0;
        m_rst     = 0;
        m_ovf     = 0;
        m_und     = 0;
    endtask

    task automatic modelEdge(input logic [2:0] phase, input bit valid,
                             input logic [7:0] data, input bit vsync);
        bit          pop_now;
        int          n;
        logic [16:0] entry;
        pop_now = (phase == 3'd5);
        n       = m_q.size();
        if (valid && vsync) begin
            m_q.delete();
            if (pop_now) begin
                m_data = '0;
                m_rst  = 0;
            end
            m_pending = 1;
            m_low     = data;
            m_tag     = 1;
        end else begin
            if (pop_now) begin
                if (n > 0) begin
                    entry  = m_q.pop_front();
                    m_data = entry[15:0];
                    m_rst  = entry[16];
                end else begin
                    m_data = '0;
                    m_rst  = 0;
                    m_und  = 1;
                end
            end
            if (valid && m_pending) begin
                if (n == DEPTH && !pop_now) m_ovf = 1;
                else m_q.push_back({m_tag, data, m_low});
                m_pending = 0;
            end else if (valid) begin
                m_pending = 1;
                m_low     = data;
                m_tag     = 0;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("fb_data", 32'(bus.fb_data), 32'(m_data));
        checkOutput("fb_reset_in", 32'(bus.fb_reset_in), 32'(m_rst));
        checkOutput("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        checkOutput("overflow", 32'(overflow), 32'(m_ovf));
        checkOutput("underrun", 32'(underrun), 32'(m_und));
    endtask

    task automatic applyStimulus(input logic [2:0] phase, input bit valid,
                                 input logic [7:0] data, input bit vsync);
        bus.clk_phase = phase;
        bus.pix_valid = valid;
        bus.pix_data  = data;
        bus.pix_vsync = vsync;
        @(posedge clk);
        modelEdge(phase, valid, data, vsync);
        #1;
        checkAll();
    endtask

    task automatic doReset();
        bus.clk_phase = 3'd0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = 8'h00;
        bus.pix_vsync = 1'b0;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_fb_data", 32'(bus.fb_data), 32'h0);
        checkOutput("rst_fb_reset_in", 32'(bus.fb_reset_in), 32'h0);
        checkOutput("rst_fifo_level", 32'(fifo_level), 32'h0);
        checkOutput("rst_overflow", 32'(overflow), 32'h0);
        checkOutput("rst_underrun", 32'(underrun), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic sendWord(input logic [2:0] phase, input logic [7:0] lo,
                            input logic [7:0] hi);
        applyStimulus(phase, 1'b1, lo, 1'b0);
        applyStimulus(phase, 1'b1, hi, 1'b0);
    endtask

    initial begin
        int ph;
        logic [2:0] p;
        bus.clk_phase = 3'd0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = 8'h00;
        bus.pix_vsync = 1'b0;
        modelReset();
        #2;

        // Scenario 1: tagged first word held through a slot, then untagged word
        doReset();
        applyStimulus(3'd0, 1'b1, 8'h11, 1'b1);
        applyStimulus(3'd1, 1'b1, 8'h22, 1'b0);
        for (int i = 2; i < 5; i++) applyStimulus(3'(i), 1'b0, 8'h00, 1'b0);
        applyStimulus(3'd5, 1'b0, 8'h00, 1'b0);
        checkOutput("s1_data", 32'(bus.fb_data), 32'h2211);
        checkOutput("s1_rst", 32'(bus.fb_reset_in), 32'h1);
        applyStimulus(3'd0, 1'b1, 8'h33, 1'b0);
        applyStimulus(3'd1, 1'b1, 8'h44, 1'b0);
        for (int i = 2; i < 5; i++) applyStimulus(3'(i), 1'b0, 8'h00, 1'b0);
        checkOutput("s1_hold", 32'(bus.fb_data), 32'h2211);
        applyStimulus(3'd5, 1'b0, 8'h00, 1'b0);
        checkOutput("s1_data2", 32'(bus.fb_data), 32'h4433);
        checkOutput("s1_rst2", 32'(bus.fb_reset_in), 32'h0);

        // Scenario 2: five words into a four-deep FIFO, phases 6/7 do not pop
        doReset();
        for (int k = 1; k <= 5; k++) sendWord(3'd0, 8'(2 * k - 1), 8'(2 * k));
        checkOutput("s2_level", 32'(fifo_level), 32'd4);
        checkOutput("s2_ovf", 32'(overflow), 32'h1);
        applyStimulus(3'd6, 1'b0, 8'h00, 1'b0);
        applyStimulus(3'd7, 1'b0, 8'h00, 1'b0);
        checkOutput("s2_level_p67", 32'(fifo_level), 32'd4);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(3'd5, 1'b0, 8'h00, 1'b0);
            checkOutput("s2_pop", 32'(bus.fb_data), 32'({8'(2 * k), 8'(2 * k - 1)}));
        end

        // Scenario 3: empty slots give idle word and underrun
        doReset();
        applyStimulus(3'd5, 1'b0, 8'h00, 1'b0);
        checkOutput("s3_data", 32'(bus.fb_data), 32'h0);
        checkOutput("s3_und", 32'(underrun), 32'h1);
        applyStimulus(3'd5, 1'b0, 8'h00, 1'b0);

        // Scenario 4: vsync flushes queue and pending low byte
        doReset();
        sendWord(3'd0, 8'h01, 8'h02);
        applyStimulus(3'd2, 1'b1, 8'hAA, 1'b0);
        applyStimulus(3'd3, 1'b1, 8'h55, 1'b1);
        checkOutput("s4_level", 32'(fifo_level), 32'd0);
        applyStimulus(3'd4, 1'b1, 8'h66, 1'b0);
        applyStimulus(3'd5, 1'b0, 8'h00, 1'b0);
        checkOutput("s4_data", 32'(bus.fb_data), 32'h6655);
        checkOutput("s4_rst", 32'(bus.fb_reset_in), 32'h1);

        // Scenario 5: push and pop on the same edge while full
        doReset();
        for (int k = 0; k < 4; k++) sendWord(3'd0, 8'(16 * k + 1), 8'(16 * k + 2));
        applyStimulus(3'd0, 1'b1, 8'h77, 1'b0);
        applyStimulus(3'd5, 1'b1, 8'h88, 1'b0);
        checkOutput("s5_level", 32'(fifo_level), 32'd4);
        checkOutput("s5_ovf", 32'(overflow), 32'h0);
        checkOutput("s5_data", 32'(bus.fb_data), 32'h0201);
        sendWord(3'd1, 8'h99, 8'h9A);
        checkOutput("s5_ovf2", 32'(overflow), 32'h1);

        // Scenario 6: reset with queued and partial data
        doReset();
        applyStimulus(3'd0, 1'b1, 8'hC0, 1'b1);
        applyStimulus(3'd1, 1'b1, 8'hC1, 1'b0);
        sendWord(3'd2, 8'hC2, 8'hC3);
        sendWord(3'd3, 8'hC4, 8'hC5);
        applyStimulus(3'd4, 1'b1, 8'hEE, 1'b0);
        checkOutput("s6_level", 32'(fifo_level), 32'd3);
        doReset();
        applyStimulus(3'd0, 1'b1, 8'h0A, 1'b0);
        applyStimulus(3'd1, 1'b1, 8'h0B, 1'b0);
        applyStimulus(3'd5, 1'b0, 8'h00, 1'b0);
        checkOutput("s6_data", 32'(bus.fb_data), 32'h0B0A);
        checkOutput("s6_rst", 32'(bus.fb_reset_in), 32'h0);

        // Randomized run with occasional phase glitches and resets
        doReset();
        ph = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) doReset();
            if ($urandom_range(0, 9) == 0) p = 3'($urandom_range(0, 7));
            else p = 3'(ph);
            ph = (ph + 1) % 6;
            applyStimulus(p, $urandom_range(0, 3) != 0, 8'($urandom),
                          $urandom_range(0, 15) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
